// File: rtl/hazard_sched.sv
// hazard_sched: pipeline sequencer deciding advance/stall/flush/bubble per
// cycle for the 4-bit-opcode CPU (load-use, multi-cycle MUL, redirects).
// Ports: clk, rst_n (sync, active-low); ID inputs id_valid/id_op/id_rs/
// id_rt/id_rd; ex_br_taken from the EX compare. Outputs pc_we, ifid_we,
// ifid_flush, idex_bubble, ex_hold, redirect_sel, busy, and perf counters
// stall_cycles/flush_count (built only when HAZ_PERF_EN is defined).
module hazard_sched #(
    parameter int MUL_CYCLES = 3,
    parameter int REG_AW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [3:0]        id_op,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_br_taken,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              ex_hold,
    output logic [1:0]        redirect_sel,
    output logic              busy,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       flush_count
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_COM  = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_BEQ  = 4'd9;
    localparam logic [3:0] OP_JUMP = 4'd10;
    localparam logic [3:0] OP_JAL  = 4'd11;
    localparam logic [3:0] OP_JR   = 4'd12;

    typedef enum logic {S_RUN, S_MUL_BUSY} state_t;

    state_t            state_q, state_d;
    logic [3:0]        mul_cnt_q, mul_cnt_d;
    logic              ex_valid_q, ex_valid_d;
    logic [3:0]        ex_op_q, ex_op_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;

    logic rs_used, rt_used;
    logic ex_redir, load_use, id_jump;

    always_comb begin
        rs_used = !(id_op == OP_JUMP || id_op == OP_JAL);
        rt_used = (id_op == OP_ADD) || (id_op == OP_SUB) ||
                  (id_op == OP_AND) || (id_op == OP_XOR) ||
                  (id_op == OP_COM) || (id_op == OP_MUL) ||
                  (id_op == OP_BEQ) || (id_op == OP_SW);
        ex_redir = ex_valid_q &&
                   ((ex_op_q == OP_BEQ && ex_br_taken) ||
                    ex_op_q == OP_JR);
        load_use = id_valid && ex_valid_q && ex_op_q == OP_LW &&
                   ex_rd_q != '0 &&
                   ((rs_used && id_rs == ex_rd_q) ||
                    (rt_used && id_rt == ex_rd_q));
        id_jump  = id_valid && (id_op == OP_JUMP || id_op == OP_JAL);
    end

    // Control outputs, highest-priority condition wins.
    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        ex_hold      = 1'b0;
        redirect_sel = 2'b00;
        busy         = 1'b0;
        if (!rst_n) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state_q == S_MUL_BUSY) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            ex_hold = 1'b1;
            busy    = 1'b1;
        end else if (ex_redir) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            redirect_sel = (ex_op_q == OP_JR) ? 2'b11 : 2'b10;
        end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_jump) begin
            ifid_flush   = 1'b1;
            redirect_sel = 2'b01;
        end
    end

    always_comb begin
        state_d    = state_q;
        mul_cnt_d  = mul_cnt_q;
        ex_valid_d = ex_valid_q;
        ex_op_d    = ex_op_q;
        ex_rd_d    = ex_rd_q;
        if (state_q == S_MUL_BUSY) begin
            mul_cnt_d = mul_cnt_q - 4'd1;
            if (mul_cnt_q <= 4'd1) begin
                state_d   = S_RUN;
                mul_cnt_d = 4'd0;
            end
        end
        if (!ex_hold) begin
            if (idex_bubble) begin
                ex_valid_d = 1'b0;
            end else begin
                ex_valid_d = id_valid;
                ex_op_d    = id_op;
                ex_rd_d    = id_rd;
                // Issuing edge of a MUL: hold EX for the remaining cycles.
                if (id_valid && id_op == OP_MUL && MUL_CYCLES > 1) begin
                    state_d   = S_MUL_BUSY;
                    mul_cnt_d = 4'(MUL_CYCLES - 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            mul_cnt_q  <= 4'd0;
            ex_valid_q <= 1'b0;
            ex_op_q    <= 4'd0;
            ex_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            mul_cnt_q  <= mul_cnt_d;
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_rd_q    <= ex_rd_d;
        end
    end

`ifdef HAZ_PERF_EN
    logic [15:0] stall_q, flush_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            if (!pc_we && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
            if (ifid_flush && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 16'd0;
    assign flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: directed + randomized bench for hazard_sched with a
// behavioural reference model of the sequencing rules.
module tb_hazard_sched;

    localparam int MC = 3;
    localparam logic [3:0] ADD = 4'd0, AND_ = 4'd2, SLL = 4'd5;
    localparam logic [3:0] MUL = 4'd6, LW = 4'd7, SW = 4'd8, BEQ = 4'd9;
    localparam logic [3:0] JUMP = 4'd10, JAL = 4'd11, JR = 4'd12;
`ifdef HAZ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, id_valid, ex_br_taken;
    logic [3:0]  id_op, id_rs, id_rt, id_rd;
    logic        pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, busy;
    logic [1:0]  redirect_sel;
    logic [15:0] stall_cycles, flush_count;
    logic [7:0]  ctl;

    int errors = 0;
    int checks = 0;

    // Reference model: contents of EX and extra cycles the MUL still owes.
    bit         m_exv = 0;
    logic [3:0] m_exop = '0;
    logic [3:0] m_exrd = '0;
    int         m_left = 0;
    int         m_stall = 0;
    int         m_flush = 0;

    always #5 clk = ~clk;

    hazard_sched #(.MUL_CYCLES(MC), .REG_AW(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_br_taken(ex_br_taken), .pc_we(pc_we), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .ex_hold(ex_hold), .redirect_sel(redirect_sel), .busy(busy),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    assign ctl = {pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold,
                  redirect_sel, busy};

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit rn, input bit v, input logic [3:0] op,
                        input logic [3:0] rs, input logic [3:0] rt,
                        input logic [3:0] rd, input bit br);
        bit e_pc, e_we, e_fl, e_bu, e_ho, e_busy, lu, rsu, rtu;
        logic [1:0] e_sel;
        @(negedge clk);
        rst_n = rn; id_valid = v; id_op = op;
        id_rs = rs; id_rt = rt; id_rd = rd; ex_br_taken = br;
        #1;
        rsu = !(op inside {JUMP, JAL});
        rtu = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, MUL, BEQ, SW};
        lu = v && m_exv && m_exop == LW && m_exrd != 0 &&
             ((rsu && rs == m_exrd) || (rtu && rt == m_exrd));
        e_pc = 1; e_we = 1; e_fl = 0; e_bu = 0; e_ho = 0;
        e_busy = 0; e_sel = 2'd0;
        if (!rn) begin
            e_pc = 0; e_we = 0; e_fl = 1; e_bu = 1;
        end else if (m_left > 0) begin
            e_pc = 0; e_we = 0; e_ho = 1; e_busy = 1;
        end else if (m_exv && ((m_exop == BEQ && br) || m_exop == JR)) begin
            e_fl = 1; e_bu = 1; e_sel = (m_exop == JR) ? 2'd3 : 2'd2;
        end else if (lu) begin
            e_pc = 0; e_we = 0; e_bu = 1;
        end else if (v && op inside {JUMP, JAL}) begin
            e_fl = 1; e_sel = 2'd1;
        end
        check("ctl", ctl, {e_pc, e_we, e_fl, e_bu, e_ho, e_sel, e_busy});
        check("exv", dut.ex_valid_q, m_exv);
        check("stall", stall_cycles, PERF ? m_stall : 0);
        check("flush", flush_count, PERF ? m_flush : 0);
        // advance the model to the state after this edge
        if (!rn) begin
            m_exv = 0; m_left = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e_pc && m_stall < 65535) m_stall++;
            if (e_fl && m_flush < 65535) m_flush++;
            if (e_ho) m_left--;
            else if (e_bu) m_exv = 0;
            else begin
                m_exv = v; m_exop = op; m_exrd = rd;
                if (v && op == MUL) m_left = MC - 1;
            end
        end
    endtask

    initial begin
        rst_n = 0; id_valid = 0; id_op = 0; id_rs = 0; id_rt = 0;
        id_rd = 0; ex_br_taken = 0;
        step(0, 0, ADD, 0, 0, 0, 0);
        step(0, 1, MUL, 1, 2, 3, 0);
        check("rst_ctl", ctl, 8'h30);

        // load-use on r3, then normal advance
        step(1, 1, LW, 0, 0, 3, 0);
        step(1, 1, ADD, 3, 5, 7, 0);
        check("lu_pc", pc_we, 0);
        step(1, 1, ADD, 3, 5, 7, 0);
        check("lu_after", ctl, 8'hC0);

        // LW r0 and unused rt: no stall
        step(1, 1, LW, 0, 0, 0, 0);
        step(1, 1, ADD, 0, 1, 2, 0);
        check("lw_r0", pc_we, 1);
        step(1, 1, LW, 0, 0, 4, 0);
        step(1, 1, SLL, 2, 4, 5, 0);
        check("sll_rt", pc_we, 1);

        // MUL occupancy and back-to-back MUL
        step(1, 1, MUL, 1, 2, 6, 0);
        step(1, 1, MUL, 1, 2, 7, 0);
        check("mul_busy", busy, 1);
        step(1, 1, MUL, 1, 2, 7, 0);
        step(1, 1, MUL, 1, 2, 7, 0);
        check("mul_run", busy, 0);
        step(1, 0, ADD, 0, 0, 0, 0);
        check("mul2_busy", busy, 1);
        step(1, 0, ADD, 0, 0, 0, 0);
        step(1, 0, ADD, 0, 0, 0, 0);

        // EX branch beats ID jump; untaken lets jump through
        step(1, 1, BEQ, 1, 2, 0, 0);
        step(1, 1, JUMP, 0, 0, 0, 1);
        check("beq_sel", redirect_sel, 2);
        step(1, 1, BEQ, 1, 2, 0, 0);
        step(1, 1, JUMP, 0, 0, 0, 0);
        check("beq_nt_sel", redirect_sel, 1);

        // JR in EX while ID would hit r3
        step(1, 1, JR, 3, 0, 3, 0);
        step(1, 1, ADD, 3, 3, 1, 0);
        check("jr_sel", redirect_sel, 3);
        check("jr_pc", pc_we, 1);

        // reset during MUL_BUSY
        step(1, 1, MUL, 1, 2, 5, 0);
        step(1, 0, ADD, 0, 0, 0, 0);
        step(0, 0, ADD, 0, 0, 0, 0);
        step(1, 0, ADD, 0, 0, 0, 0);
        check("rst_busy", busy, 0);
        check("rst_exv", dut.ex_valid_q, 0);
        step(1, 1, MUL, 1, 2, 5, 0);
        for (int i = 0; i < 3; i++) step(1, 0, ADD, 0, 0, 0, 0);
        check("mul_stall", stall_cycles, PERF ? 2 : 0);

        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 49) != 0, $urandom_range(0, 7) != 0,
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline sequencer for the 4-bit-opcode CPU. Decides, per cycle, whether PC, IF/ID and ID/EX advance, stall, flush or take a bubble.
- Covers load-use stalls, multi-cycle MUL occupancy of EX, and control-transfer redirects (JUMP/JAL in ID; BEQ/JR in EX).
- Sits beside the opcode decoder. Keeps its own registered shadow of the instruction occupying EX.

Parameters:
- MUL_CYCLES, 3, cycles a MUL occupies EX; legal 1..15
- REG_AW, 4, register-address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_op  in  4  ID opcode (define.v macros)
- id_rs  in  REG_AW  ID source 1
- id_rt  in  REG_AW  ID source 2
- id_rd  in  REG_AW  ID destination
- ex_br_taken  in  1  datapath compare result for the instruction in EX
- pc_we  out  1  PC load enable
- ifid_we  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_bubble  out  1  ID/EX loads a NOP
- ex_hold  out  1  EX/MEM inputs held; EX re-executes
- redirect_sel  out  2  00 PC+1, 01 ID jump target, 10 EX branch target, 11 EX JR register
- busy  out  1  state==MUL_BUSY
- stall_cycles  out  16  perf counter (see Optional Feature)
- flush_count  out  16  perf counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Registered state:
  - state: RUN or MUL_BUSY
  - mul_cnt: 4 bits
  - EX shadow: ex_valid_q, ex_op_q, ex_rd_q
- Reset (rst_n low at posedge): state=RUN, mul_cnt=0, ex_valid_q=0, perf counters=0.
- Outputs while rst_n is low: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, ex_hold=0, redirect_sel=00, busy=0. Same if reset arrives mid-MUL.
- All other outputs are combinational from state, shadow and inputs.
- Default in RUN: pc_we=1, ifid_we=1, all other controls 0, redirect_sel=00.
- Priority, highest first:
  1. MUL_BUSY: pc_we=0, ifid_we=0, ex_hold=1, idex_bubble=0.
  2. EX redirect: ex_valid_q and ((ex_op_q==BEQ and ex_br_taken) or ex_op_q==JR). Outputs: pc_we=1, ifid_flush=1, idex_bubble=1, redirect_sel=10 (BEQ) or 11 (JR). Load-use and ID jump are ignored (wrong path).
  3. Load-use: all of the following hold →
     - id_valid
     - ex_valid_q and ex_op_q==LW
     - ex_rd_q!=0
     - id_rs==ex_rd_q with rs used, or id_rt==ex_rd_q with rt used
     - Response: pc_we=0, ifid_we=0, idex_bubble=1. Exactly one cycle.
     - rs is used by every op except JUMP and JAL.
     - rt is used by ADD, SUB, AND, XOR, COM, MUL, BEQ, SW.
  4. ID jump: id_valid and id_op in {JUMP, JAL} → pc_we=1, ifid_flush=1, redirect_sel=01. The instruction still issues to EX; JAL needs the link write.
- Shadow update at posedge:
  - ex_hold=1: hold.
  - else idex_bubble=1: ex_valid_q<=0.
  - else: load id_valid, id_op, id_rd.
- MUL sequencing:
  - On an edge in RUN that loads a valid MUL into the shadow with MUL_CYCLES>1: state<=MUL_BUSY, mul_cnt<=MUL_CYCLES-1.
  - In MUL_BUSY: mul_cnt decrements each edge. The edge where it reaches 0 returns state to RUN.
  - Net effect: MUL_BUSY lasts MUL_CYCLES-1 cycles, followed by one RUN cycle in which the MUL completes and the pipeline advances. Total EX occupancy is MUL_CYCLES cycles.
  - MUL_CYCLES=1: never enter MUL_BUSY.
  - Back-to-back MULs re-enter MUL_BUSY on the issuing edge.
- ex_br_taken is ignored unless ex_op_q==BEQ.

Optional Feature:
- Macro: HAZ_PERF_EN.
- Defined:
  - stall_cycles increments on every cycle with pc_we=0 while rst_n is high.
  - flush_count increments on every cycle with ifid_flush=1 while rst_n is high.
  - Both are 16-bit and saturate at 16'hFFFF.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- LW r3 in EX, ID=ADD rs=3 rt=5 → one cycle with pc_we=0, ifid_we=0, idex_bubble=1. Next cycle: ex_valid_q=0 and normal advance.
- LW r0 in EX, ID=ADD rs=0 → no stall. LW r4 in EX, ID=SLL rs=2 rt=4 → no stall (rt unused by SLL).
- MUL issued with MUL_CYCLES=3 → busy=1 and ex_hold=1 for 2 cycles, pc_we low for 2 cycles, then one RUN cycle. Second MUL in ID → busy again immediately after.
- BEQ in EX with ex_br_taken=1, JUMP in ID same cycle → redirect_sel=10, ifid_flush=1, idex_bubble=1; JUMP ignored. Same with ex_br_taken=0 → redirect_sel=01.
- JR in EX while ID shows a load-use hazard → redirect_sel=11, no stall (pc_we=1).
- rst_n low mid-MUL_BUSY → at next edge busy=0, ex_valid_q=0. With HAZ_PERF_EN defined: counters are 0 after reset, and stall_cycles=2 after one MUL with MUL_CYCLES=3.
